l1_dcache_ctrl: RTL and testbench

//  Sequencing controller for the 16 KB, 4-way, 32 B-line L1 data cache: write-back, write-allocate.

---
 rtl/l1_dcache_pkg.sv | 40 ++++
 rtl/l1_dcache_ctrl_if.sv | 43 ++++
 rtl/l1_dcache_ctrl_plru_tree.sv | 41 ++++
 rtl/l1_dcache_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/l1_dcache_pkg.sv
// Shared geometry, FSM state encoding and address-field helpers for the L1 D-cache controller.
package l1_dcache_pkg;

  localparam int unsigned SETS       = 128;
  localparam int unsigned WAYS       = 4;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned INDEX_W    = $clog2(SETS);
  localparam int unsigned WAY_W      = $clog2(WAYS);
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS);
  localparam int unsigned OFFS_W     = WORD_W + 2;
  localparam int unsigned TAG_W      = 32 - OFFS_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESP,
    S_WB_RD,
    S_WB_WR,
    S_REFILL_REQ,
    S_REFILL
  } state_e;

  // Word address (byte offset dropped) split into cache fields
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  word;
  } waddr_t;

  function automatic waddr_t split_addr(input logic [31:2] wa);
    return waddr_t'(wa);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index,
                                            input logic [WORD_W-1:0]  word);
    return {tag, index, word, 2'b00};
  endfunction

endpackage

// File: rtl/l1_dcache_ctrl_if.sv
// Core request/response, data-array and memory-port signals of the L1 D-cache controller.
// master: controller side; slave: environment (core, array, memory) side.
interface l1_dcache_ctrl_if;
  import l1_dcache_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               arr_en;
  logic               arr_we;
  logic [INDEX_W-1:0] arr_set;
  logic [WAY_W-1:0]   arr_way;
  logic [WORD_W-1:0]  arr_word;
  logic [31:0]        arr_wdata;
  logic [31:0]        arr_rdata;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [31:0]        mem_req_addr;
  logic [31:0]        mem_req_wdata;
  logic               mem_resp_valid;
  logic [31:0]        mem_resp_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, arr_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata,
           arr_en, arr_we, arr_set, arr_way, arr_word, arr_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, arr_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata,
           arr_en, arr_we, arr_set, arr_way, arr_word, arr_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/l1_dcache_ctrl_plru_tree.sv
// 3-bit tree pseudo-LRU per set. Node bits point toward the victim side:
// bit0 selects half (0: ways 0/1, 1: ways 2/3), bit1/bit2 select within each half.
module plru_tree
  import l1_dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_set,
  output logic [WAY_W-1:0]   victim,
  input  logic               upd_en,
  input  logic [INDEX_W-1:0] upd_set,
  input  logic [WAY_W-1:0]   upd_way
);

  logic [2:0] tree_q [SETS];
  logic [2:0] tree_d [SETS];
  logic [2:0] rd_tree;

  // Victim follows the node bits of the looked-up set
  always_comb begin
    rd_tree = tree_q[rd_set];
    victim  = rd_tree[0] ? {1'b1, rd_tree[2]} : {1'b0, rd_tree[1]};
  end

  // On access, point every node on the path away from the accessed way
  always_comb begin
    tree_d = tree_q;
    if (upd_en) begin
      tree_d[upd_set][0] = ~upd_way[1];
      if (upd_way[1]) tree_d[upd_set][2] = ~upd_way[0];
      else            tree_d[upd_set][1] = ~upd_way[0];
    end
  end

  // Tree state register, cleared for every set in a single reset cycle
  always_ff @(posedge clk) begin
    if (!reset) tree_q <= '{default: '0};
    else        tree_q <= tree_d;
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// L1 D-cache sequencing controller: write-back, write-allocate, 4-way, one request in flight.
// Owns tag/valid/dirty state and drives an external data array with 1-cycle read latency.
module l1_dcache_ctrl
  import l1_dcache_pkg::*;
(
  input logic              clk,
  input logic              reset,
  l1_dcache_ctrl_if.master bus
);

  state_e             state_q, state_d;
  waddr_t             addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [WORD_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]   vway_q, vway_d;
  logic               rd_pend_q, rd_pend_d;
  logic [TAG_W-1:0]   tag_q [SETS][WAYS];
  logic [TAG_W-1:0]   tag_d [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    valid_d [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];
  logic [WAYS-1:0]    dirty_d [SETS];

  logic               hit, inv_found, plru_upd;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];

  plru_tree u_plru (
    .clk     (clk),
    .reset   (reset),
    .rd_set  (addr_q.index),
    .victim  (plru_victim),
    .upd_en  (plru_upd),
    .upd_set (addr_q.index),
    .upd_way (hit_way)
  );

  // Tag match and lowest-invalid-way search over the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[addr_q.index][WAY_W'(w)] &&
          tag_q[addr_q.index][WAY_W'(w)] == addr_q.tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[addr_q.index][WAY_W'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Next-state, metadata updates and all port outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    vway_d    = vway_q;
    rd_pend_d = 1'b0;
    tag_d     = tag_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    plru_upd  = 1'b0;

    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = '0;
    bus.arr_en        = 1'b0;
    bus.arr_we        = 1'b0;
    bus.arr_set       = '0;
    bus.arr_way       = '0;
    bus.arr_word      = '0;
    bus.arr_wdata     = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = split_addr(bus.req_addr[31:2]);
          wdata_d = bus.req_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          plru_upd     = 1'b1;
          bus.arr_en   = 1'b1;
          bus.arr_set  = addr_q.index;
          bus.arr_way  = hit_way;
          bus.arr_word = addr_q.word;
          if (we_q) begin
            bus.arr_we                       = 1'b1;
            bus.arr_wdata                    = wdata_q;
            dirty_d[addr_q.index][hit_way]   = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          vway_d = inv_found ? inv_way : plru_victim;
          cnt_d  = '0;
          if (!inv_found && dirty_q[addr_q.index][plru_victim]) state_d = S_WB_RD;
          else                                                  state_d = S_REFILL_REQ;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = we_q ? '0 : bus.arr_rdata;
        state_d        = S_IDLE;
      end
      S_WB_RD: begin
        bus.arr_en   = 1'b1;
        bus.arr_set  = addr_q.index;
        bus.arr_way  = vway_q;
        bus.arr_word = cnt_q;
        rd_pend_d    = 1'b1;
        state_d      = S_WB_WR;
      end
      S_WB_WR: begin
        // Array data is only valid on the first WB_WR cycle; hold it for a stalled beat
        wb_data_d         = rd_pend_q ? bus.arr_rdata : wb_data_q;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = beat_addr(tag_q[addr_q.index][vway_q], addr_q.index, cnt_q);
        bus.mem_req_wdata = wb_data_d;
        if (bus.mem_req_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == '1) ? S_REFILL_REQ : S_WB_RD;
        end
      end
      S_REFILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = beat_addr(addr_q.tag, addr_q.index, '0);
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_resp_valid) begin
          bus.arr_en    = 1'b1;
          bus.arr_we    = 1'b1;
          bus.arr_set   = addr_q.index;
          bus.arr_way   = vway_q;
          bus.arr_word  = cnt_q;
          bus.arr_wdata = bus.mem_resp_rdata;
          cnt_d         = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            tag_d[addr_q.index][vway_q]   = addr_q.tag;
            valid_d[addr_q.index][vway_q] = 1'b1;
            dirty_d[addr_q.index][vway_q] = 1'b0;
            state_d                       = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and metadata registers; reset abandons any transaction and clears valid/dirty
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
      vway_q    <= '0;
      rd_pend_q <= 1'b0;
      valid_q   <= '{default: '0};
      dirty_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
      vway_q    <= vway_d;
      rd_pend_q <= rd_pend_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
    end
  end

  // Tag storage carries no reset: every compare is gated by valid
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: models the data array and the L2/memory port,
// checks responses, writeback beats and refill requests against hand-computed values.
module tb_l1_dcache_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  l1_dcache_ctrl_if bus ();

  l1_dcache_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External data array: synchronous write, 1-cycle read latency
  logic [31:0] darr [4096];
  always @(posedge clk) begin
    if (bus.arr_en) begin
      if (bus.arr_we) darr[{bus.arr_set, bus.arr_way, bus.arr_word}] <= bus.arr_wdata;
      else            bus.arr_rdata <= darr[{bus.arr_set, bus.arr_way, bus.arr_word}];
    end
  end

  // Backing-memory contents as a function of word address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Results of the most recent transaction
  logic [31:0] r_rdata, r_rd_addr;
  int          r_lat, r_acc, r_wb_n, r_rd_n, r_rd_at_wb, r_stall_bad;
  bit          r_resp, r_pulse_ok;
  logic [31:0] wb_addr [16];
  logic [31:0] wb_data [16];

  // One core transaction plus the memory side; called and returns at a negedge
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, input int stall, input int abort_beat);
    int n, acc_n, stall_left, rf_beat;
    bit rf_mode, hold_set, aborted, done;
    logic [31:0] h_addr, h_data, rf_line;
    r_rdata = '0; r_rd_addr = '0; r_lat = -1; r_acc = 0; r_wb_n = 0; r_rd_n = 0;
    r_rd_at_wb = -1; r_stall_bad = 0; r_resp = 0; r_pulse_ok = 0;
    n = 0; acc_n = 0; stall_left = stall; rf_beat = 0; rf_mode = 0;
    hold_set = 0; aborted = 0; done = 0; h_addr = '0; h_data = '0; rf_line = '0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    while (!done && n < 400) begin
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
      if (bus.resp_valid) begin
        r_resp = 1; r_rdata = bus.resp_rdata; r_lat = n - acc_n; done = 1;
      end else begin
        if (bus.req_valid && bus.req_ready) begin r_acc++; acc_n = n; end
        if (rf_mode) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = mem_val(rf_line + 32'(rf_beat * 4));
          if (rf_beat == abort_beat) begin reset = 1'b0; aborted = 1; end
          rf_beat++;
          if (rf_beat == 8) rf_mode = 0;
        end else if (bus.mem_req_valid && bus.mem_req_we) begin
          if (stall_left > 0) begin
            if (!hold_set) begin
              h_addr = bus.mem_req_addr; h_data = bus.mem_req_wdata; hold_set = 1;
            end else if (bus.mem_req_addr !== h_addr || bus.mem_req_wdata !== h_data) begin
              r_stall_bad++;
            end
            stall_left--;
          end else begin
            bus.mem_req_ready = 1'b1;
            if (r_wb_n < 16) begin
              wb_addr[r_wb_n] = bus.mem_req_addr; wb_data[r_wb_n] = bus.mem_req_wdata;
            end
            r_wb_n++;
          end
        end else if (bus.mem_req_valid) begin
          bus.mem_req_ready = 1'b1;
          r_rd_n++; r_rd_addr = bus.mem_req_addr; r_rd_at_wb = r_wb_n;
          rf_mode = 1; rf_beat = 0; rf_line = bus.mem_req_addr;
        end
        @(negedge clk);
        n++;
        if (r_acc > 0 && !hold) bus.req_valid = 1'b0;
        if (aborted) done = 1;
      end
    end
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    if (!done) chk("txn_timeout", 32'(n), 32'd0);
    if (r_resp) begin
      @(negedge clk);
      r_pulse_ok = !bus.resp_valid;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    bus.arr_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_arr_en", 32'(bus.arr_en), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Cold load: miss, no writeback, line read at 0x1000, beat 1 returned
    run_txn(1'b0, 32'h0000_1004, '0, 0, 0, -1);
    chk("cold_resp", 32'(r_resp), 32'd1);
    chk("cold_rdata", r_rdata, mem_val(32'h0000_1004));
    chk("cold_wb_beats", 32'(r_wb_n), 32'd0);
    chk("cold_rd_reqs", 32'(r_rd_n), 32'd1);
    chk("cold_rd_addr", r_rd_addr, 32'h0000_1000);
    chk("cold_pulse", 32'(r_pulse_ok), 32'd1);

    run_txn(1'b0, 32'h0000_1004, '0, 0, 0, -1);
    chk("hit_rdata", r_rdata, mem_val(32'h0000_1004));
    chk("hit_latency", 32'(r_lat), 32'd2);
    chk("hit_rd_reqs", 32'(r_rd_n), 32'd0);
    chk("hit_pulse", 32'(r_pulse_ok), 32'd1);

    // Store hit then load of the same word
    run_txn(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 0, 0, -1);
    chk("st_hit_latency", 32'(r_lat), 32'd2);
    chk("st_hit_rd_reqs", 32'(r_rd_n), 32'd0);
    chk("st_rdata_zero", r_rdata, 32'd0);
    run_txn(1'b0, 32'h0000_1008, '0, 0, 0, -1);
    chk("ld_after_st_rdata", r_rdata, 32'hDEAD_BEEF);
    chk("ld_after_st_latency", 32'(r_lat), 32'd2);
    chk("ld_after_st_rd_reqs", 32'(r_rd_n), 32'd0);

    // Fill the rest of set 0 with dirty lines (ways 1..3)
    for (int k = 2; k <= 4; k++) begin
      run_txn(1'b1, 32'(k) << 12, 32'hA0 + 32'(k), 0, 0, -1);
      chk("fill_rd_reqs", 32'(r_rd_n), 32'd1);
      chk("fill_wb_beats", 32'(r_wb_n), 32'd0);
    end
    run_txn(1'b1, 32'h0000_1000, 32'h0000_00B1, 0, 0, -1);
    chk("first_line_st_rd_reqs", 32'(r_rd_n), 32'd0);
    chk("first_line_st_latency", 32'(r_lat), 32'd2);

    // Fifth tag: PLRU victim is way 2 (line 0x3000); first WB beat stalled 10 cycles
    run_txn(1'b0, 32'h0000_5004, '0, 0, 10, -1);
    chk("evict_wb_beats", 32'(r_wb_n), 32'd8);
    chk("evict_rd_after_wb", 32'(r_rd_at_wb), 32'd8);
    chk("evict_rd_addr", r_rd_addr, 32'h0000_5000);
    chk("evict_rdata", r_rdata, mem_val(32'h0000_5004));
    chk("evict_stall_stable", 32'(r_stall_bad), 32'd0);
    for (int b = 0; b < 8; b++) begin
      chk("evict_wb_addr", wb_addr[b], 32'h0000_3000 + 32'(b * 4));
      chk("evict_wb_data", wb_data[b],
          (b == 0) ? 32'h0000_00A3 : mem_val(32'h0000_3000 + 32'(b * 4)));
    end

    // Next victim is way 1 (line 0x2000, dirty); reset lands on refill beat 4
    run_txn(1'b0, 32'h0000_6000, '0, 0, 0, 4);
    chk("abort_no_resp", 32'(r_resp), 32'd0);
    chk("abort_wb_beats", 32'(r_wb_n), 32'd8);
    chk("abort_wb_addr0", wb_addr[0], 32'h0000_2000);
    chk("abort_wb_data0", wb_data[0], 32'h0000_00A2);
    chk("abort_rd_addr", r_rd_addr, 32'h0000_6000);
    chk("abort_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Previously resident line now misses
    run_txn(1'b0, 32'h0000_1004, '0, 0, 0, -1);
    chk("post_rst_rd_reqs", 32'(r_rd_n), 32'd1);
    chk("post_rst_wb_beats", 32'(r_wb_n), 32'd0);
    chk("post_rst_rdata", r_rdata, mem_val(32'h0000_1004));

    // req_valid held high across back-to-back hits
    run_txn(1'b0, 32'h0000_1004, '0, 1, 0, -1);
    chk("hold1_accepts", 32'(r_acc), 32'd1);
    chk("hold1_latency", 32'(r_lat), 32'd2);
    chk("hold1_pulse", 32'(r_pulse_ok), 32'd1);
    run_txn(1'b0, 32'h0000_1008, '0, 1, 0, -1);
    bus.req_valid = 1'b0;
    chk("hold2_accepts", 32'(r_acc), 32'd1);
    chk("hold2_rdata", r_rdata, mem_val(32'h0000_1008));
    chk("hold2_pulse", 32'(r_pulse_ok), 32'd1);
    @(negedge clk);
    chk("idle_after_hold", 32'(bus.req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
